// File: rtl/mmio_gpio.sv
// mmio_gpio: memory-mapped GPIO block on the CPU data bus.
// Registered outputs, synchronised and debounced inputs, programmable
// edge detection and a maskable level interrupt with W1C status.
// Word offsets: 0 OUT, 1 IN, 2 IRQ_EN, 3 IRQ_STAT, 4 EDGE_POL, 5..7 reserved.
module mmio_gpio #(
  parameter logic [15:0] BASE_ADDR = 16'hC000,
  parameter int          N_OUT     = 10,
  parameter int          N_IN      = 10,
  parameter int          DB_CYCLES = 4,
  parameter int          CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      addr,
  input  logic             we,
  input  logic             re,
  input  logic [15:0]      wdata,
  output logic [15:0]      rdata,
  output logic             sel,
  input  logic [N_IN-1:0]  gpio_in,
  output logic [N_OUT-1:0] gpio_out,
  output logic             irq
);

  // Address decode: the block occupies eight consecutive words.
  logic       hit;
  logic [2:0] off;
  assign hit = (addr[15:3] == BASE_ADDR[15:3]);
  assign off = addr[2:0];
  assign sel = re & hit;

  logic wr_out, wr_en, wr_stat, wr_pol;
  assign wr_out  = we & hit & (off == 3'd0);
  assign wr_en   = we & hit & (off == 3'd2);
  assign wr_stat = we & hit & (off == 3'd3);
  assign wr_pol  = we & hit & (off == 3'd4);

  // Architectural and pipeline state.
  logic [N_OUT-1:0] out_reg;
  logic [N_IN-1:0]  irq_en_reg;
  logic [N_IN-1:0]  irq_stat_reg;
  logic [N_IN-1:0]  edge_pol_reg;
  logic [N_IN-1:0]  s1_reg;
  logic [N_IN-1:0]  s2_reg;
  logic [N_IN-1:0]  db_reg;
  logic [CNT_W-1:0] cnt_reg  [N_IN];

  logic [N_IN-1:0]  db_next;
  logic [CNT_W-1:0] cnt_next [N_IN];
  logic [N_IN-1:0]  ev;
  logic [N_IN-1:0]  w1c_mask;
  logic [N_IN-1:0]  irq_stat_next;

  // Per-bit debounce: a synchronised value must differ from db for
  // DB_CYCLES consecutive edges; any return to db restarts the count.
  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_db
      logic differs;
      logic done;
      assign differs = (s2_reg[gi] != db_reg[gi]);
      assign done    = (cnt_reg[gi] == CNT_W'(DB_CYCLES - 1));
      assign db_next[gi]  = (differs && done) ? s2_reg[gi] : db_reg[gi];
      assign cnt_next[gi] = (differs && !done) ? cnt_reg[gi] + 1'b1 : '0;
    end
  endgenerate

  // Edge event on the debounced value, filtered by the per-bit polarity.
  assign ev = (db_next & ~db_reg & edge_pol_reg) | (~db_next & db_reg & ~edge_pol_reg);

  // A new event wins over a simultaneous write-1-to-clear on the same bit.
  assign w1c_mask      = wr_stat ? wdata[N_IN-1:0] : '0;
  assign irq_stat_next = (irq_stat_reg & ~w1c_mask) | ev;

  // Register updates: bus writes, synchroniser, debounce and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg      <= '0;
      irq_en_reg   <= '0;
      irq_stat_reg <= '0;
      edge_pol_reg <= '1;
      s1_reg       <= '0;
      s2_reg       <= '0;
      db_reg       <= '0;
      for (int i = 0; i < N_IN; i++) cnt_reg[i] <= '0;
    end else begin
      if (wr_out) out_reg      <= wdata[N_OUT-1:0];
      if (wr_en)  irq_en_reg   <= wdata[N_IN-1:0];
      if (wr_pol) edge_pol_reg <= wdata[N_IN-1:0];
      irq_stat_reg <= irq_stat_next;
      s1_reg       <= gpio_in;
      s2_reg       <= s1_reg;
      db_reg       <= db_next;
      for (int i = 0; i < N_IN; i++) cnt_reg[i] <= cnt_next[i];
    end
  end

  // Combinational read mux; unselected or reserved reads return zero.
  logic [15:0] rdata_mux;
  always_comb begin
    rdata_mux = '0;
    if (sel) begin
      case (off)
        3'd0:    rdata_mux[N_OUT-1:0] = out_reg;
        3'd1:    rdata_mux[N_IN-1:0]  = db_reg;
        3'd2:    rdata_mux[N_IN-1:0]  = irq_en_reg;
        3'd3:    rdata_mux[N_IN-1:0]  = irq_stat_reg;
        3'd4:    rdata_mux[N_IN-1:0]  = edge_pol_reg;
        default: rdata_mux = '0;
      endcase
    end
  end

  assign rdata    = rdata_mux;
  assign gpio_out = out_reg;
  // Interrupt is formed only from registered state, so it cannot glitch.
  assign irq      = |(irq_stat_reg & irq_en_reg);

  // Upper write-data bits are intentionally ignored when pins are narrower.
  logic unused_bits;
  assign unused_bits = ^{wdata, BASE_ADDR[2:0]};

endmodule

// File: doc/mmio_gpio.md
Name: mmio_gpio

Overview:
- Parametrised memory-mapped GPIO peripheral on the CPU data bus (addr/we/re/wdata/rdata).
- Next generation of the fixed LED-at-C000 / switch-at-C001 decode.
- Adds parametrised widths and base address, a 2-flop input synchroniser, per-bit debounce, programmable edge detection, and a maskable interrupt with write-1-to-clear status.
- One instance drives board LEDs and samples switches/keys; further instances may sit at other bases.

Parameters:
- BASE_ADDR, 16'hC000: register block base; must be 8-word aligned (BASE_ADDR[2:0]==0).
- N_OUT, 10: output pin count, 1..16.
- N_IN, 10: input pin count, 1..16.
- DB_CYCLES, 4: consecutive stable cycles needed before a synchronised input is accepted, >=1.
- CNT_W, 3: debounce counter width, must satisfy 2**CNT_W >= DB_CYCLES.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- addr  input  16  CPU word address.
- we  input  1  write strobe, one cycle per access.
- re  input  1  read strobe.
- wdata  input  16  write data.
- rdata  output  16  read data; 0 when not selected.
- sel  output  1  high when re & addr in [BASE_ADDR, BASE_ADDR+7]; used by top-level rdata OR-mux.
- gpio_in  input  N_IN  asynchronous pins (switches/keys).
- gpio_out  output  N_OUT  registered pin drive (LEDs).
- irq  output  1  level interrupt.

Behaviour:
- Clocking/reset: one clock, clk. Reset is synchronous, active-high (rst). All state changes on posedge clk only.
- Reset values: gpio_out=0, IRQ_EN=0, IRQ_STAT=0, EDGE_POL=all 1 (rising), sync flops=0, debounced value db=0, counters=0, irq=0.
- Decode: hit = (addr[15:3]==BASE_ADDR[15:3]); off = addr[2:0].
- Register map, bits above the field width read 0 and are ignored on write:
  - off 0 OUT: RW; write sets gpio_out <= wdata[N_OUT-1:0] at the next edge.
  - off 1 IN: RO, returns db. Writes are ignored.
  - off 2 IRQ_EN: RW, N_IN bits.
  - off 3 IRQ_STAT: read returns status; a write clears each bit where wdata=1 (W1C).
  - off 4 EDGE_POL: RW, N_IN bits; 1=rising, 0=falling.
  - off 5..7: reserved; read 0, writes ignored.
- Reads: combinational. rdata = register value when re & hit, else 16'h0000; no wait states. A write is visible to a read in the cycle after we.
- Synchroniser: s1<=gpio_in; s2<=s1.
- Debounce, per bit i:
  - if s2[i]==db[i]: cnt[i]<=0.
  - else if cnt[i]==DB_CYCLES-1: db[i]<=s2[i], cnt[i]<=0.
  - else: cnt[i]++.
  - A pin change captured at edge E0 appears in db at edge E0+1+DB_CYCLES.
  - Any bounce back to db before the count completes restarts the count from 0.
- Edge detect: ev[i] = (db_next[i]&~db[i]&EDGE_POL[i]) | (~db_next[i]&db[i]&~EDGE_POL[i]).
  - ev[i] sets IRQ_STAT[i] in the same edge db updates.
  - Status is set regardless of IRQ_EN.
- Simultaneous W1C and ev on the same bit in the same cycle: the set wins, so the bit stays 1.
- irq = |(IRQ_STAT & IRQ_EN), taken from registers; glitch-free. Enabling a bit that is already pending raises irq the cycle after the IRQ_EN write.
- we & re in the same cycle: read returns the pre-write value; the write takes effect.
- rst asserted mid-operation: all state returns to reset values at that edge; in-progress debounce counts are discarded.

Test Plan:
- Reset: assert rst 2 cycles with gpio_in=10'h3FF -> gpio_out=0, irq=0. Read off1 returns 0 until 2+DB_CYCLES edges after release, then 16'h03FF.
- LED write/readback: we, addr=C000, wdata=16'hFFFF -> gpio_out=10'h3FF next cycle; read C000 returns 16'h03FF. Read C005 returns 0. Read addr=C008 -> sel=0, rdata=0.
- Debounce glitch (DB_CYCLES=4): toggle gpio_in[0] high for 3 cycles then low -> IN stays 0, IRQ_STAT stays 0. Hold high 6 cycles -> IN[0]=1 exactly 5 edges after capture.
- Edge IRQ: EDGE_POL=0 (falling), IRQ_EN=1 on bit 0; pin 1->0 stable -> IRQ_STAT=16'h0001, irq=1. Rising edge on bit 0 causes no set.
- W1C with simultaneous edge: write C003=16'h0003 in the cycle bit1 edge fires -> IRQ_STAT=16'h0002, bit0 cleared, irq follows IRQ_EN.
- Mid-operation reset: rst pulse while IRQ_STAT=3 and a count is in progress -> all registers 0, EDGE_POL=all 1, irq=0 the next cycle.
